// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and frame constants for the SPI ADC scanner.
// The averaging option is selected by the ADC_SCAN_AVG_EN macro in adc_scan_ctrl.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } scan_state_t;

  // Start + SGL/DIFF + 3 channel bits are clocked out before the sample slot
  localparam int CMD_BITS    = 5;
  // One AD_CLK period in which the ADC samples and emits its null bit
  localparam int NULL_BITS   = 1;
  // Conversions summed per channel when averaging is built in
  localparam int AVG_SAMPLES = 4;

  // Number of AD_CLK rising edges in one conversion frame
  function automatic int frame_len(input int adc_bits);
    return CMD_BITS + NULL_BITS + adc_bits;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: divides clk into the SPI AD_CLK. Each AD_CLK level lasts
// CLK_DIV clks. rise_stb/fall_stb are high on the clk cycle whose closing edge
// moves AD_CLK high/low, so logic registered on a strobe changes on the same
// clk edge as AD_CLK. With en low the divider is cleared and AD_CLK held low.
module adc_sclk_gen #(
  parameter int CLK_DIV = 1350
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic ad_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] div_cnt_reg;
  logic          ad_clk_reg;
  logic          tick;

  assign tick     = en && (div_cnt_reg == CW'(CLK_DIV - 1));
  assign rise_stb = tick & ~ad_clk_reg;
  assign fall_stb = tick & ad_clk_reg;
  assign ad_clk   = ad_clk_reg;

  // Half-period counter; toggles AD_CLK at terminal count, idles low when disabled
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt_reg <= '0;
      ad_clk_reg  <= 1'b0;
    end else if (tick) begin
      div_cnt_reg <= '0;
      ad_clk_reg  <= ~ad_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: MCP300x-style SPI ADC scanner. Walks the enabled channels in
// ascending order, one SPI frame per conversion, and presents {channel, code}
// on a valid/ready port. Optional macro ADC_SCAN_AVG_EN: four frames per
// channel, result is the truncated mean of the four codes.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int ADC_BITS = 10,
  parameter int CLK_DIV  = 1350,
  parameter int CS_GAP   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont_en,
  input  logic                diff_mode,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                AD_CLK,
  output logic                CS,
  output logic                DIN,
  input  logic                DOUT,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2:0]          res_ch,
  output logic [ADC_BITS-1:0] res_data,
  output logic                busy,
  output logic                overrun
);

  localparam int FRAME_LEN = frame_len(ADC_BITS);
  localparam int RC_W      = $clog2(FRAME_LEN + 1);
  localparam int GAP_CLKS  = CS_GAP * 2 * CLK_DIV;
  localparam int GC_W      = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  scan_state_t         state_reg;
  logic                cs_reg;
  logic                din_reg;
  logic                busy_reg;
  logic                sclk_en_reg;
  logic                load_pend_reg;
  logic [NUM_CH-1:0]   mask_reg;
  logic [2:0]          cur_ch_reg;
  logic [3:0]          cmd_sr_reg;
  logic [RC_W-1:0]     rise_cnt_reg;
  logic [GC_W-1:0]     gap_cnt_reg;
  logic [ADC_BITS-1:0] data_sr_reg;

  logic                res_valid_reg;
  logic [2:0]          res_ch_reg;
  logic [ADC_BITS-1:0] res_data_reg;
  logic                overrun_reg;

  logic                rise_stb;
  logic                fall_stb;
  logic                sclk_out;

  logic [NUM_CH-1:0]   above_mask;
  logic [2:0]          first_ch;
  logic                first_vld;
  logic [2:0]          next_ch;
  logic                next_vld;
  logic                repeat_ch;
  logic                load;
  logic [ADC_BITS-1:0] load_data;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sclk_en_reg),
    .ad_clk   (sclk_out),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Latched-mask bits strictly above the channel just converted
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
    assign above_mask[gi] = mask_reg[gi] && (int'(cur_ch_reg) < gi);
  end

  // Lowest enabled channel of the live mask (scan start) and of the remainder
  always_comb begin
    first_ch  = '0;
    first_vld = 1'b0;
    next_ch   = '0;
    next_vld  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch  = 3'(i);
        first_vld = 1'b1;
      end
      if (above_mask[i]) begin
        next_ch  = 3'(i);
        next_vld = 1'b1;
      end
    end
  end

`ifdef ADC_SCAN_AVG_EN
  logic [ADC_BITS+1:0] acc_reg;
  logic [ADC_BITS+1:0] acc_sum;
  logic [1:0]          avg_cnt_reg;

  assign acc_sum   = acc_reg + {2'b00, data_sr_reg};
  assign repeat_ch = (avg_cnt_reg != 2'd0);
  assign load      = load_pend_reg && (avg_cnt_reg == 2'(AVG_SAMPLES - 1));
  assign load_data = acc_sum[ADC_BITS+1:2];

  // Sum conversions of the current channel; cleared once the mean is emitted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      avg_cnt_reg <= '0;
    end else if (load_pend_reg) begin
      if (avg_cnt_reg == 2'(AVG_SAMPLES - 1)) begin
        acc_reg     <= '0;
        avg_cnt_reg <= '0;
      end else begin
        acc_reg     <= acc_sum;
        avg_cnt_reg <= avg_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign repeat_ch = 1'b0;
  assign load      = load_pend_reg;
  assign load_data = data_sr_reg;
`endif

  // Scan sequencer: frame timing, command shifting, DOUT capture, channel walk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cs_reg        <= 1'b1;
      din_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      sclk_en_reg   <= 1'b0;
      load_pend_reg <= 1'b0;
      mask_reg      <= '0;
      cur_ch_reg    <= '0;
      cmd_sr_reg    <= '0;
      rise_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      data_sr_reg   <= '0;
    end else begin
      load_pend_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && first_vld) begin
            mask_reg     <= ch_mask;
            cur_ch_reg   <= first_ch;
            busy_reg     <= 1'b1;
            cs_reg       <= 1'b0;
            din_reg      <= 1'b1;
            sclk_en_reg  <= 1'b1;
            cmd_sr_reg   <= {~diff_mode, first_ch};
            rise_cnt_reg <= '0;
            state_reg    <= SETUP;
          end
        end

        SETUP: begin
          if (rise_stb) begin
            rise_cnt_reg <= RC_W'(1);
            state_reg    <= SHIFT;
          end
        end

        SHIFT: begin
          if (rise_stb) begin
            rise_cnt_reg <= rise_cnt_reg + 1'b1;
            // Rises after the null slot carry the code, MSB first
            if (rise_cnt_reg >= RC_W'(CMD_BITS + NULL_BITS)) begin
              data_sr_reg <= {data_sr_reg[ADC_BITS-2:0], DOUT};
            end
            if (rise_cnt_reg == RC_W'(FRAME_LEN - 1)) begin
              load_pend_reg <= 1'b1;
            end
          end
          if (fall_stb) begin
            if (rise_cnt_reg == RC_W'(FRAME_LEN)) begin
              cs_reg      <= 1'b1;
              din_reg     <= 1'b0;
              sclk_en_reg <= 1'b0;
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end else begin
              // Zeros shift in behind the command, giving DIN=0 from rise 6 on
              din_reg    <= cmd_sr_reg[3];
              cmd_sr_reg <= {cmd_sr_reg[2:0], 1'b0};
            end
          end
        end

        GAP: begin
          if (gap_cnt_reg == GC_W'(GAP_CLKS - 1)) begin
            if (repeat_ch || next_vld || (cont_en && first_vld)) begin
              cs_reg       <= 1'b0;
              din_reg      <= 1'b1;
              sclk_en_reg  <= 1'b1;
              rise_cnt_reg <= '0;
              state_reg    <= SETUP;
              if (repeat_ch) begin
                cmd_sr_reg <= {~diff_mode, cur_ch_reg};
              end else if (next_vld) begin
                cur_ch_reg <= next_ch;
                cmd_sr_reg <= {~diff_mode, next_ch};
              end else begin
                mask_reg   <= ch_mask;
                cur_ch_reg <= first_ch;
                cmd_sr_reg <= {~diff_mode, first_ch};
              end
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Result holding register with overwrite detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_ch_reg    <= '0;
      res_data_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (load) begin
        res_valid_reg <= 1'b1;
        res_ch_reg    <= cur_ch_reg;
        res_data_reg  <= load_data;
        overrun_reg   <= res_valid_reg & ~res_ready;
      end else if (res_valid_reg && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign AD_CLK    = sclk_out;
  assign CS        = cs_reg;
  assign DIN       = din_reg;
  assign busy      = busy_reg;
  assign res_valid = res_valid_reg;
  assign res_ch    = res_ch_reg;
  assign res_data  = res_data_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed bench for adc_scan_ctrl with an MCP300x-style
// ADC model. Single-channel frames are table driven; multi-channel, overrun,
// reset-abort, empty-mask and (with ADC_SCAN_AVG_EN) averaging are hand sequences.
module tb_adc_scan_ctrl;

  localparam int NUM_CH   = 8;
  localparam int ADC_BITS = 10;
  localparam int CLK_DIV  = 2;
  localparam int CS_GAP   = 2;
  localparam int FL       = 6 + ADC_BITS;
`ifdef ADC_SCAN_AVG_EN
  localparam int FPC = 4;
`else
  localparam int FPC = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                cont_en;
  logic                diff_mode;
  logic [NUM_CH-1:0]   ch_mask;
  logic                AD_CLK;
  logic                CS;
  logic                DIN;
  logic                DOUT = 1'b0;
  logic                res_valid;
  logic                res_ready;
  logic [2:0]          res_ch;
  logic [ADC_BITS-1:0] res_data;
  logic                busy;
  logic                overrun;

  always #5 clk = ~clk;

  adc_scan_ctrl #(
    .NUM_CH   (NUM_CH),
    .ADC_BITS (ADC_BITS),
    .CLK_DIV  (CLK_DIV),
    .CS_GAP   (CS_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont_en   (cont_en),
    .diff_mode (diff_mode),
    .ch_mask   (ch_mask),
    .AD_CLK    (AD_CLK),
    .CS        (CS),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ch    (res_ch),
    .res_data  (res_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  // ---------------- ADC model ----------------
  logic [ADC_BITS-1:0] code_tab [NUM_CH];
  int                  bfm_k       = 0;
  logic [2:0]          bfm_ch      = '0;
  logic [ADC_BITS-1:0] bfm_word    = '0;
  logic [4:0]          din_bits    = '0;
  int                  last_rises  = 0;
  int                  bfm_frames  = 0;
  int                  base_frames = 0;
  bit                  inc_en      = 1'b0;

  always @(AD_CLK, CS) begin
    if (CS === 1'b1) begin
      if (bfm_k != 0) begin
        last_rises = bfm_k;
        if (bfm_k == FL) bfm_frames++;
      end
      bfm_k = 0;
      DOUT  = 1'b0;
    end else if (AD_CLK === 1'b1) begin
      bfm_k++;
      if (bfm_k <= 5) din_bits = {din_bits[3:0], DIN};
      if (bfm_k >= 3 && bfm_k <= 5) bfm_ch = {bfm_ch[1:0], DIN};
    end else if (CS === 1'b0) begin
      if (bfm_k == 6)
        bfm_word = code_tab[bfm_ch] +
                   (inc_en ? ADC_BITS'((bfm_frames - base_frames) % 4) : ADC_BITS'(0));
      if (bfm_k >= 6 && bfm_k < FL) DOUT = bfm_word[ADC_BITS + 5 - bfm_k];
      else DOUT = 1'b0;
    end
  end

  int ovr_seen = 0;
  always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [NUM_CH-1:0]   mask;
    logic                diff;
    logic [4:0]          din;
    logic [2:0]          ch;
    logic [ADC_BITS-1:0] data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int f0;
    int o0;
    int bad;
    logic [2:0]          exp_ch [3];
    logic [ADC_BITS-1:0] exp_dt [3];

    for (int i = 0; i < NUM_CH; i++) code_tab[i] = ADC_BITS'(8'h11 * i);
    code_tab[0] = 10'h2A5;
    code_tab[2] = 10'h155;
    code_tab[3] = 10'h3C3;
    code_tab[5] = 10'h0F0;
    code_tab[7] = 10'h301;

    //             mask    diff  DIN rises 1..5  ch    code
    vecs[0] = '{8'h01, 1'b0, 5'b11000, 3'd0, 10'h2A5};
    vecs[1] = '{8'h08, 1'b1, 5'b10011, 3'd3, 10'h3C3};
    vecs[2] = '{8'h80, 1'b0, 5'b11111, 3'd7, 10'h301};
    vecs[3] = '{8'h20, 1'b1, 5'b10101, 3'd5, 10'h0F0};

    rst_n = 1'b0; start = 1'b0; cont_en = 1'b0; diff_mode = 1'b0;
    ch_mask = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_adclk", 32'(AD_CLK), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_ch", 32'(res_ch), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one-shot single-channel frames
    for (int v = 0; v < 4; v++) begin
      ch_mask = vecs[v].mask;
      diff_mode = vecs[v].diff;
      pulse_start();
      check("vec_busy_on", 32'(busy), 32'd1);
      wait_valid(4000, ok);
      check("vec_valid_timeout", 32'(ok), 32'd1);
      check("vec_ch", 32'(res_ch), 32'(vecs[v].ch));
      check("vec_data", 32'(res_data), 32'(vecs[v].data));
      $display("vec %0d: mask %h diff %0d -> ch %0d data %h", v, vecs[v].mask,
               vecs[v].diff, res_ch, res_data);
      @(negedge clk);
      check("vec_valid_drop", 32'(res_valid), 32'd0);
      wait_idle(2000, ok);
      check("vec_idle_timeout", 32'(ok), 32'd1);
      check("vec_din_bits", 32'(din_bits), 32'(vecs[v].din));
      check("vec_rises", 32'(last_rises), 32'(FL));
      check("vec_cs_idle", 32'(CS), 32'd1);
    end

    // Multi-channel one-shot scan: 2, 5, 7 in order, then stop
    exp_ch = '{3'd2, 3'd5, 3'd7};
    exp_dt = '{10'h155, 10'h0F0, 10'h301};
    ch_mask = 8'hA4; diff_mode = 1'b0; f0 = bfm_frames;
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      wait_valid(4000, ok);
      check("scan_valid_timeout", 32'(ok), 32'd1);
      check("scan_ch", 32'(res_ch), 32'(exp_ch[r]));
      check("scan_data", 32'(res_data), 32'(exp_dt[r]));
      $display("scan result %0d: ch %0d data %h", r, res_ch, res_data);
    end
    wait_idle(2000, ok);
    check("scan_idle_timeout", 32'(ok), 32'd1);
    repeat (200) @(negedge clk);
    check("scan_frames", 32'(bfm_frames - f0), 32'(3 * FPC));
    check("scan_busy_off", 32'(busy), 32'd0);

    // Continuous with consumer stalled: second result overwrites the first
    ch_mask = 8'h01; cont_en = 1'b1; res_ready = 1'b0; o0 = ovr_seen;
    pulse_start();
    wait_valid(4000, ok);
    check("ovr_first_timeout", 32'(ok), 32'd1);
    check("ovr_first_data", 32'(res_data), 32'h2A5);
    code_tab[0] = 10'h1C7;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (ovr_seen != o0) begin ok = 1'b1; break; end
    end
    cont_en = 1'b0;
    check("ovr_pulse_timeout", 32'(ok), 32'd1);
    wait_idle(4000, ok);
    check("ovr_idle_timeout", 32'(ok), 32'd1);
    check("ovr_count", 32'(ovr_seen - o0), 32'd1);
    check("ovr_valid_held", 32'(res_valid), 32'd1);
    check("ovr_latest_data", 32'(res_data), 32'h1C7);
    check("ovr_ch", 32'(res_ch), 32'd0);
    $display("overrun: pulses %0d data %h", ovr_seen - o0, res_data);
    res_ready = 1'b1;
    @(negedge clk);
    check("ovr_accept_drop", 32'(res_valid), 32'd0);
    code_tab[0] = 10'h2A5;

    // Reset at rise 9 aborts the frame and discards the partial result
    ch_mask = 8'h01;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bfm_k == 9) begin ok = 1'b1; break; end
    end
    check("abort_rise9_timeout", 32'(ok), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs", 32'(CS), 32'd1);
    check("abort_adclk", 32'(AD_CLK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || CS !== 1'b1) bad++;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    pulse_start();
    wait_valid(4000, ok);
    check("abort_restart_timeout", 32'(ok), 32'd1);
    check("abort_restart_data", 32'(res_data), 32'h2A5);
    wait_idle(2000, ok);
    check("abort_restart_rises", 32'(last_rises), 32'(FL));
    $display("reset abort: restart ch %0d data %h", res_ch, res_data);

    // Empty mask: start ignored
    ch_mask = '0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || CS !== 1'b1 || AD_CLK !== 1'b0) bad++;
    end
    check("empty_mask_idle", 32'(bad), 32'd0);
    $display("empty mask: activity cycles %0d", bad);

`ifdef ADC_SCAN_AVG_EN
    // Averaging: codes 100..103 on ch3 average to 101
    code_tab[3] = 10'd100; inc_en = 1'b1; base_frames = bfm_frames;
    ch_mask = 8'h08; diff_mode = 1'b0;
    pulse_start();
    wait_valid(8000, ok);
    check("avg_valid_timeout", 32'(ok), 32'd1);
    check("avg_ch", 32'(res_ch), 32'd3);
    check("avg_data", 32'(res_data), 32'd101);
    $display("average: ch %0d data %0d", res_ch, res_data);
    wait_idle(2000, ok);
    check("avg_idle_timeout", 32'(ok), 32'd1);
    inc_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
